pong_match_ctrl: RTL and testbench
==================================

Name: pong_match_ctrl

Overview:
- Match sequencer for the pong game. It sits between the ball/bar animators and the board I/O.
- Turns the raw START button and the ball's per-point score flags into a round flow: idle, serve, play, point pause, game over.
- Holds the ball during non-play states, keeps both players' scores as ASCII digits for the score display, and declares a winner at WIN_SCORE.
- Frame-based timing uses the VGA end-of-frame animate strobe.

Parameters:
- WIN_SCORE, 5: points needed to win a match (1..9).
- PAUSE_FRAMES, 60: frames the ball stays held after a point, before returning to SERVE (>=1).
- AUTO_SERVE_FRAMES, 180: frames in SERVE before an automatic serve (only with AUTO_SERVE_EN; >=1).
- ASCII_BASE, 8'h30: code emitted for a score of 0.

Ports:
- in_clock  input  1  system clock, 50 MHz.
- in_reset_n  input  1  asynchronous active-low reset.
- in_animate  input  1  one-cycle end-of-frame strobe.
- in_start  input  1  start button level, already synchronous to in_clock.
- in_left_score  input  1  player1-scored flag from the ball animator (level; may stay high several cycles).
- in_right_score  input  1  player2-scored flag (same convention).
- out_ball_hold  output  1  1 = ball frozen at centre; 0 = ball free to move.
- out_serve_dir  output  1  0 = next serve travels left, 1 = travels right.
- out_point  output  1  one-cycle pulse when a point is accepted.
- out_state  output  3  current state code.
- out_player1  output  8  player1 score, ASCII.
- out_player2  output  8  player2 score, ASCII.
- out_winner  output  2  00 none, 01 player1, 10 player2.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; out_ball_hold 1; out_serve_dir 0; out_point 0.
  - Scores = ASCII_BASE; out_winner 00; frame counter 0.
  - All edge-detect history registers 0.
- Edge detection:
  - Registered copies of in_start, in_left_score and in_right_score.
  - rise = input & ~previous.
  - Only rising edges act, so a held button or held score flag counts once.
- State codes: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4. Codes 5–7 are illegal and return to IDLE on the next clock.
- All outputs are registered. A qualifying event in cycle N is visible on the outputs at cycle N+1.
- IDLE:
  - start rise -> SERVE; both scores cleared to ASCII_BASE; winner 00.
- SERVE:
  - out_ball_hold 1.
  - start rise -> PLAY; out_ball_hold drops to 0 in the same transition.
- PLAY:
  - out_ball_hold 0.
  - left rise -> player1 += 1, out_point pulse, out_serve_dir <= 1.
  - right rise -> player2 += 1, out_point pulse, out_serve_dir <= 0.
  - Both rises in the same cycle: left has priority; the right rise is discarded, not deferred.
  - If the incremented score equals ASCII_BASE+WIN_SCORE -> OVER, out_winner set to that player. Otherwise -> POINT with frame counter cleared.
  - start rise is ignored.
- POINT:
  - out_ball_hold 1.
  - Each in_animate increments the frame counter.
  - When the counter reaches PAUSE_FRAMES: -> SERVE, counter cleared.
  - start rise is ignored.
- OVER:
  - out_ball_hold 1; scores and winner frozen.
  - start rise -> SERVE; scores cleared; winner 00; out_serve_dir kept.
- Score rises outside PLAY are ignored; scores never change outside PLAY, IDLE->SERVE or OVER->SERVE.
- Width rules:
  - Scores are 8-bit, incremented by 1; they cannot pass ASCII_BASE+WIN_SCORE, so there is no wrap.
  - Frame counter width = clog2(max(PAUSE_FRAMES, AUTO_SERVE_FRAMES)+1).
- Reset mid-round: immediate return to the reset values above, regardless of state or pending edges.
- in_animate coincident with a state change: the counter effect is applied only in POINT (or SERVE with the optional feature). A strobe on the entering transition is not counted.

Optional Feature:
- Macro: PONG_AUTO_SERVE_EN.
- Defined:
  - In SERVE the frame counter counts in_animate strobes.
  - When it reaches AUTO_SERVE_FRAMES: -> PLAY, as if start rose, counter cleared.
  - A start rise before then serves immediately and clears the counter.
- Not defined: SERVE waits indefinitely for start; no counter activity in SERVE.

Test Plan:
- Reset, then start pulse -> state 0->1 next clock; out_player1/2 = 8'h30; out_ball_hold 1. Second start pulse -> state 2, out_ball_hold 0.
- In PLAY, hold in_left_score high for 5 cycles -> out_player1 = 8'h31 (single increment), one out_point pulse, out_serve_dir 1, state 3. After 60 in_animate strobes -> state 1.
- Left and right rises in the same cycle -> player1 8'h31, player2 8'h30, only one out_point.
- Five player2 points -> out_player2 8'h35, out_winner 10, state 4. Start -> state 1, scores 8'h30, winner 00.
- Score rises and start presses during POINT and OVER-hold -> no score change. Drive in_reset_n low mid-POINT -> state 0 and all outputs at reset values asynchronously.
- With PONG_AUTO_SERVE_EN: in SERVE, 180 strobes with no start -> state 2. Without the macro, the same stimulus leaves state 1.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: idle/serve/play/point/over flow, ASCII scores, winner.
// Define PONG_AUTO_SERVE_EN to serve automatically after AUTO_SERVE_FRAMES.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE         = 5,
  parameter int unsigned PAUSE_FRAMES      = 60,
  parameter int unsigned AUTO_SERVE_FRAMES = 180,
  parameter logic [7:0]  ASCII_BASE        = 8'h30
) (
  input  logic       in_clock,
  input  logic       in_reset_n,
  input  logic       in_animate,
  input  logic       in_start,
  input  logic       in_left_score,
  input  logic       in_right_score,
  output logic       out_ball_hold,
  output logic       out_serve_dir,
  output logic       out_point,
  output logic [2:0] out_state,
  output logic [7:0] out_player1,
  output logic [7:0] out_player2,
  output logic [1:0] out_winner
);

  localparam int unsigned MAX_F =
    (PAUSE_FRAMES > AUTO_SERVE_FRAMES) ? PAUSE_FRAMES : AUTO_SERVE_FRAMES;
  localparam int unsigned CW = $clog2(MAX_F + 1);
  localparam logic [CW-1:0] PAUSE_C = CW'(PAUSE_FRAMES);
`ifdef PONG_AUTO_SERVE_EN
  localparam logic [CW-1:0] AUTO_C = CW'(AUTO_SERVE_FRAMES);
`endif
  localparam logic [7:0] WIN_C = ASCII_BASE + 8'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          hold_q, hold_d;
  logic          dir_q, dir_d;
  logic          point_q, point_d;
  logic [7:0]    p1_q, p1_d;
  logic [7:0]    p2_q, p2_d;
  logic [1:0]    win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, left_q, right_q;

  logic          start_rise, left_rise, right_rise;
  logic [7:0]    p1_inc, p2_inc;
  logic [CW-1:0] cnt_inc;

  assign start_rise = in_start & ~start_q;
  assign left_rise  = in_left_score & ~left_q;
  assign right_rise = in_right_score & ~right_q;
  assign p1_inc     = p1_q + 8'd1;
  assign p2_inc     = p2_q + 8'd1;
  assign cnt_inc    = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    point_d = 1'b0;
    p1_d    = p1_q;
    p2_d    = p2_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          state_d = S_SERVE;
          p1_d    = ASCII_BASE;
          p2_d    = ASCII_BASE;
          win_d   = 2'b00;
          cnt_d   = '0;
        end
      end
      S_SERVE: begin
        if (start_rise) begin
          state_d = S_PLAY;
          cnt_d   = '0;
        end
`ifdef PONG_AUTO_SERVE_EN
        else if (in_animate) begin
          if (cnt_inc == AUTO_C) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
`endif
      end
      S_PLAY: begin
        // Left wins a same-cycle tie; the right rise is dropped.
        if (left_rise) begin
          p1_d    = p1_inc;
          dir_d   = 1'b1;
          point_d = 1'b1;
          cnt_d   = '0;
          if (p1_inc == WIN_C) begin
            state_d = S_OVER;
            win_d   = 2'b01;
          end else begin
            state_d = S_POINT;
          end
        end else if (right_rise) begin
          p2_d    = p2_inc;
          dir_d   = 1'b0;
          point_d = 1'b1;
          cnt_d   = '0;
          if (p2_inc == WIN_C) begin
            state_d = S_OVER;
            win_d   = 2'b10;
          end else begin
            state_d = S_POINT;
          end
        end
      end
      S_POINT: begin
        if (in_animate) begin
          if (cnt_inc == PAUSE_C) begin
            state_d = S_SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    hold_d = (state_d != S_PLAY);
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= S_IDLE;
      hold_q  <= 1'b1;
      dir_q   <= 1'b0;
      point_q <= 1'b0;
      p1_q    <= ASCII_BASE;
      p2_q    <= ASCII_BASE;
      win_q   <= 2'b00;
      cnt_q   <= '0;
      start_q <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      dir_q   <= dir_d;
      point_q <= point_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      start_q <= in_start;
      left_q  <= in_left_score;
      right_q <= in_right_score;
    end
  end

  assign out_state     = state_q;
  assign out_ball_hold = hold_q;
  assign out_serve_dir = dir_q;
  assign out_point     = point_q;
  assign out_player1   = p1_q;
  assign out_player2   = p2_q;
  assign out_winner    = win_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed scenarios plus
// randomized play compared against a game-level reference model.
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       anim = 1'b0, start = 1'b0, lsc = 1'b0, rsc = 1'b0;
  logic       out_ball_hold, out_serve_dir, out_point;
  logic [2:0] out_state;
  logic [7:0] out_player1, out_player2;
  logic [1:0] out_winner;

  always #5 clk = ~clk;

  pong_match_ctrl dut (
    .in_clock      (clk),
    .in_reset_n    (rst_n),
    .in_animate    (anim),
    .in_start      (start),
    .in_left_score (lsc),
    .in_right_score(rsc),
    .out_ball_hold (out_ball_hold),
    .out_serve_dir (out_serve_dir),
    .out_point     (out_point),
    .out_state     (out_state),
    .out_player1   (out_player1),
    .out_player2   (out_player2),
    .out_winner    (out_winner)
  );

`ifdef PONG_AUTO_SERVE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // Game-level model: phase names, point counts, strobes seen in a phase.
  int m_st, m_p1, m_p2, m_win, m_frames;
  bit m_dir, m_point, ps, pl, pr;

  wire [23:0] dut_vec = {out_state, out_ball_hold, out_serve_dir, out_point,
                         out_player1, out_player2, out_winner};

  function automatic logic [23:0] exp_vec();
    return {3'(m_st), (m_st != 2), m_dir, m_point,
            8'(48 + m_p1), 8'(48 + m_p2), 2'(m_win)};
  endfunction

  function automatic void model_reset();
    m_st = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_frames = 0;
    m_dir = 0; m_point = 0; ps = 0; pl = 0; pr = 0;
  endfunction

  function automatic void new_match();
    m_st = 1; m_p1 = 0; m_p2 = 0; m_win = 0; m_frames = 0;
  endfunction

  function automatic void model_step(bit s, bit l, bit r, bit a);
    bit sr, lr, rr;
    sr = s && !ps; lr = l && !pl; rr = r && !pr;
    ps = s; pl = l; pr = r;
    m_point = 0;
    if (m_st == 0 || m_st == 4) begin
      if (sr) new_match();
    end else if (m_st == 1) begin
      if (sr) begin
        m_st = 2; m_frames = 0;
      end else if (AUTO && a) begin
        m_frames++;
        if (m_frames == 180) begin m_st = 2; m_frames = 0; end
      end
    end else if (m_st == 2) begin
      if (lr || rr) begin
        m_point = 1; m_frames = 0;
        if (lr) begin m_p1++; m_dir = 1; end
        else begin m_p2++; m_dir = 0; end
        if (m_p1 == 5) begin m_st = 4; m_win = 1; end
        else if (m_p2 == 5) begin m_st = 4; m_win = 2; end
        else m_st = 3;
      end
    end else if (m_st == 3) begin
      if (a) begin
        m_frames++;
        if (m_frames == 60) begin m_st = 1; m_frames = 0; end
      end
    end
  endfunction

  task automatic cyc(input bit s, input bit l, input bit r, input bit a);
    start = s; lsc = l; rsc = r; anim = a;
    @(posedge clk);
    model_step(s, l, r, a);
    #1;
  endtask

  task automatic do_reset();
    start = 0; lsc = 0; rsc = 0; anim = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (out_state !== 3'd0 || out_ball_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state got st=%0d hold=%b exp st=0 hold=1",
               out_state, out_ball_hold);
    end
    n_checks++;
    if (out_player1 !== 8'h30 || out_player2 !== 8'h30 || out_winner !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_scores got %h %h w=%b exp 30 30 w=00",
               out_player1, out_player2, out_winner);
    end
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_vec got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_start();
    cyc(1, 0, 0, 0);
    n_checks++;
    if (out_state !== 3'd1 || out_ball_hold !== 1'b1 || out_player1 !== 8'h30) begin
      n_fail++;
      $display("FAIL start_serve got st=%0d hold=%b p1=%h exp st=1 hold=1 p1=30",
               out_state, out_ball_hold, out_player1);
    end
    cyc(1, 0, 0, 0);
    n_checks++;
    if (out_state !== 3'd1) begin
      n_fail++;
      $display("FAIL start_held got st=%0d exp 1", out_state);
    end
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    n_checks++;
    if (out_state !== 3'd2 || out_ball_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL start_play got st=%0d hold=%b exp st=2 hold=0",
               out_state, out_ball_hold);
    end
  endtask

  task automatic test_point_hold();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0);
      n_checks++;
      if (out_player1 !== 8'h31 || out_point !== (i == 0) ||
          out_state !== 3'd3 || out_serve_dir !== 1'b1) begin
        n_fail++;
        $display("FAIL held_left[%0d] got p1=%h pt=%b st=%0d dir=%b exp p1=31 pt=%0d st=3 dir=1",
                 i, out_player1, out_point, out_state, out_serve_dir, (i == 0));
      end
    end
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      cyc(0, 0, 0, 1);
      n_checks++;
      if (out_state !== ((i == 59) ? 3'd1 : 3'd3)) begin
        n_fail++;
        $display("FAIL pause_frame[%0d] got st=%0d exp %0d",
                 i, out_state, (i == 59) ? 1 : 3);
      end
      cyc(0, 0, 0, 0);
    end
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL pause_vec got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    n_checks++;
    if (out_player1 !== 8'h31 || out_player2 !== 8'h30 || out_point !== 1'b1) begin
      n_fail++;
      $display("FAIL tie got p1=%h p2=%h pt=%b exp p1=31 p2=30 pt=1",
               out_player1, out_player2, out_point);
    end
    cyc(0, 0, 1, 0);
    n_checks++;
    if (out_point !== 1'b0 || out_player2 !== 8'h30) begin
      n_fail++;
      $display("FAIL tie_after got pt=%b p2=%h exp pt=0 p2=30",
               out_point, out_player2);
    end
  endtask

  task automatic test_win();
    do_reset();
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      if (k < 4) begin
        repeat (60) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
      end
    end
    n_checks++;
    if (out_player2 !== 8'h35 || out_winner !== 2'b10 || out_state !== 3'd4) begin
      n_fail++;
      $display("FAIL win got p2=%h w=%b st=%0d exp p2=35 w=10 st=4",
               out_player2, out_winner, out_state);
    end
    cyc(0, 1, 0, 1); cyc(0, 0, 1, 0);
    n_checks++;
    if (out_player1 !== 8'h30 || out_player2 !== 8'h35 || out_winner !== 2'b10) begin
      n_fail++;
      $display("FAIL over_frozen got p1=%h p2=%h w=%b exp 30 35 10",
               out_player1, out_player2, out_winner);
    end
    cyc(1, 0, 0, 0);
    n_checks++;
    if (out_state !== 3'd1 || out_player2 !== 8'h30 || out_winner !== 2'b00 ||
        out_serve_dir !== 1'b0) begin
      n_fail++;
      $display("FAIL rematch got st=%0d p2=%h w=%b dir=%b exp st=1 p2=30 w=00 dir=0",
               out_state, out_player2, out_winner, out_serve_dir);
    end
  endtask

  task automatic test_ignored();
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0); cyc(1, 0, 1, 0); cyc(0, 1, 0, 0);
    n_checks++;
    if (out_player1 !== 8'h31 || out_player2 !== 8'h30 || out_state !== 3'd3) begin
      n_fail++;
      $display("FAIL point_ignore got p1=%h p2=%h st=%0d exp 31 30 3",
               out_player1, out_player2, out_state);
    end
  endtask

  task automatic test_async_reset();
    start = 0; lsc = 0; rsc = 0; anim = 0;
    #2 rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (out_state !== 3'd0 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL async_reset got %h exp %h", dut_vec, exp_vec());
    end
    @(posedge clk);
    #1 rst_n = 1;
    cyc(0, 0, 0, 0);
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_serve_wait();
    do_reset();
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    for (int i = 0; i < 180; i++) begin
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
    end
    n_checks++;
    if (out_state !== (AUTO ? 3'd2 : 3'd1)) begin
      n_fail++;
      $display("FAIL serve_wait got st=%0d exp %0d", out_state, AUTO ? 2 : 1);
    end
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL serve_vec got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    bit s, l, r, a;
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      s = ($urandom_range(0, 9) == 0);
      l = ($urandom_range(0, 5) == 0) || (lsc && $urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 5) == 0) || (rsc && $urandom_range(0, 1) == 1);
      a = $urandom_range(0, 1) == 1;
      cyc(s, l, r, a);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d] got %h exp %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_point_hold();
    test_simultaneous();
    test_win();
    test_ignored();
    test_async_reset();
    test_serve_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
